control_sequencer: RTL and testbench

Hardwired control FSM for the ARM-subset datapath. It fetches an instruction and evaluates its condition field against the NZCV flags. It then sequences data-processing, LDR/STR and B instructions by driving every datapath mux select (MA, MB, MC, MD), the ALU opcode and the register/memory load strobes. It sits directly upstream of the datapath select muxes and handshakes with memory through mfa/moc.

---
 rtl/ctrl_pkg.sv | 75 +++++++
 rtl/cond_eval.sv | 48 ++++
 rtl/control_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the ARM-subset control sequencer: FSM state
// encoding, ALU opcodes driven by the controller, datapath mux-select codes
// and ARM condition-code values.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // FSM states (4-bit, also exported on the debug 'state' port)
    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F0  = 4'd1,   // MAR <- PC
        S_F1  = 4'd2,   // instruction read wait
        S_F2  = 4'd3,   // IR load, PC <- PC + 4
        S_DEC = 4'd4,   // condition check and dispatch
        S_DP  = 4'd5,   // data-processing execute
        S_LA  = 4'd6,   // LDR address
        S_LW  = 4'd7,   // LDR memory wait
        S_LB  = 4'd8,   // LDR write-back
        S_SA  = 4'd9,   // STR address
        S_SD  = 4'd10,  // STR data into MDR
        S_SW  = 4'd11,  // STR memory wait
        S_BR  = 4'd12,  // branch: PC <- PC + offset
        S_BL  = 4'd13   // branch-with-link: R14 <- PC
    } state_t;

    // Controller-supplied ALU opcodes
    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_PASSB = 5'd13;
    localparam logic [4:0] OP_INC4  = 5'd20;

    // MA: A-port address select
    localparam logic [1:0] MA_RN = 2'd0;    // ir[19:16]
    localparam logic [1:0] MA_RD = 2'd1;
    localparam logic [1:0] MA_PC = 2'd2;    // R15

    // MB: B-operand select
    localparam logic [1:0] MB_REG   = 2'd0;
    localparam logic [1:0] MB_SHIFT = 2'd1;
    localparam logic [1:0] MB_MDR   = 2'd2;
    localparam logic [1:0] MB_CONST = 2'd3;

    // MC: register-file write-address select
    localparam logic [2:0] MC_RD  = 3'd0;
    localparam logic [2:0] MC_R14 = 3'd2;
    localparam logic [2:0] MC_PC  = 3'd3;

    // MD: ALU opcode source
    localparam logic MD_IR = 1'b0;          // ir[24:21]
    localparam logic MD_OP = 1'b1;          // OP port

    // ME: MDR source
    localparam logic ME_MEM = 1'b0;
    localparam logic ME_ALU = 1'b1;

    // ARM condition codes (ir[31:28])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition-field evaluator.
// Ports:
//   i_cond  [3:0]  condition field, ir[31:28]
//   i_flags [3:0]  N,Z,C,V on bits 3..0
//   o_pass         1 when the instruction should execute (NV/4'hF -> 0)
// ---------------------------------------------------------------------------
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // the output unassigned and infers a latch.
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;     // 4'hF never executes
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control FSM for the ARM-subset datapath: fetch, condition check,
// then data-processing, LDR/STR and B/BL sequencing. Outputs are a Moore
// decode of the state register; abort is a registered one-cycle pulse.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ir    [31:0]          instruction register contents
//   flags [3:0]           N,Z,C,V (sampled only while decoding)
//   moc                   memory operation complete (used in wait states)
//   MA, MB, MC, MD, OP    datapath mux selects and ALU opcode
//   ME                    MDR source select
//   rf_we, ir_ld, mar_ld, mdr_ld, flags_ld   load strobes
//   mfa, rw               memory request and direction (1 = read)
//   abort                 pulse after a memory wait times out
//   state [3:0]           current state (debug)
// ---------------------------------------------------------------------------
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic [3:0]  flags,
    input  logic        moc,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [2:0]  MC,
    output logic        MD,
    output logic [4:0]  OP,
    output logic        ME,
    output logic        rf_we,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        flags_ld,
    output logic        mfa,
    output logic        rw,
    output logic        abort,
    output logic [3:0]  state
);

    // Last count value at which a wait may still stay put; the wait lasts
    // MEM_TIMEOUT cycles in total before aborting.
    localparam logic [3:0] C_CNT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_abort;

    state_t     w_dec_next;
    logic       w_cond_pass;
    logic       w_in_wait;
    logic       w_timeout;
    logic       w_unused;

    // Operand/register fields of ir are consumed by the datapath, not here.
    assign w_unused = ^{ir[22:21], ir[19:0]};

    cond_eval u_cond_eval (
        .i_cond  (ir[31:28]),
        .i_flags (flags),
        .o_pass  (w_cond_pass)
    );

    assign w_in_wait = (r_state == S_F1) || (r_state == S_LW) || (r_state == S_SW);
    // moc has priority: a completion on the last allowed cycle is not an abort.
    assign w_timeout = w_in_wait && !moc && (r_cnt == C_CNT_LAST);

    // Dispatch from S_DEC
    always_comb begin
        w_dec_next = S_F0;
        if (w_cond_pass) begin
            if (ir[27:26] == 2'b00) begin
                w_dec_next = S_DP;
            end else if (ir[27:26] == 2'b01) begin
                w_dec_next = ir[20] ? S_LA : S_SA;
            end else if (ir[27:25] == 3'b101) begin
                // BL writes R14 from the current PC before the PC is changed.
                w_dec_next = ir[24] ? S_BL : S_BR;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            // Count stays cleared outside waits, so each wait starts at 0.
            r_cnt   <= (w_in_wait && !moc) ? r_cnt + 4'd1 : 4'd0;

            case (r_state)
                S_RST: r_state <= S_F0;
                S_F0:  r_state <= S_F1;
                S_F1: begin
                    if (moc)            r_state <= S_F2;
                    else if (w_timeout) r_state <= S_F0;
                end
                S_F2:  r_state <= S_DEC;
                S_DEC: r_state <= w_dec_next;
                S_DP:  r_state <= S_F0;
                S_LA:  r_state <= S_LW;
                S_LW: begin
                    if (moc)            r_state <= S_LB;
                    else if (w_timeout) r_state <= S_F0;
                end
                S_LB:  r_state <= S_F0;
                S_SA:  r_state <= S_SD;
                S_SD:  r_state <= S_SW;
                S_SW: begin
                    if (moc || w_timeout) r_state <= S_F0;
                end
                S_BR:  r_state <= S_F0;
                S_BL:  r_state <= S_BR;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        MA       = MA_RN;
        MB       = MB_REG;
        MC       = MC_RD;
        MD       = MD_IR;
        OP       = OP_NONE;
        ME       = ME_MEM;
        rf_we    = 1'b0;
        ir_ld    = 1'b0;
        mar_ld   = 1'b0;
        mdr_ld   = 1'b0;
        flags_ld = 1'b0;
        mfa      = 1'b0;
        rw       = 1'b1;
        case (r_state)
            S_F0: begin
                MA     = MA_PC;
                MB     = MB_CONST;
                MD     = MD_OP;
                mar_ld = 1'b1;
            end
            S_F1, S_LW: begin
                mfa    = 1'b1;
                mdr_ld = 1'b1;
            end
            S_F2: begin
                ir_ld = 1'b1;
                MA    = MA_PC;
                MD    = MD_OP;
                OP    = OP_INC4;
                MC    = MC_PC;
                rf_we = 1'b1;
            end
            S_DP: begin
                MB       = MB_SHIFT;
                rf_we    = 1'b1;
                flags_ld = ir[20];
            end
            S_LA, S_SA: begin
                MB     = MB_SHIFT;
                MD     = MD_OP;
                OP     = ir[23] ? OP_ADD : OP_SUB;
                mar_ld = 1'b1;
            end
            S_LB: begin
                MB    = MB_MDR;
                MD    = MD_OP;
                OP    = OP_PASSB;
                rf_we = 1'b1;
            end
            S_SD: begin
                MA     = MA_RD;
                MD     = MD_OP;
                OP     = OP_PASSB;
                ME     = ME_ALU;
                mdr_ld = 1'b1;
            end
            S_SW: begin
                mfa = 1'b1;
                rw  = 1'b0;
            end
            S_BR: begin
                MA    = MA_PC;
                MB    = MB_SHIFT;
                MD    = MD_OP;
                OP    = OP_ADD;
                MC    = MC_PC;
                rf_we = 1'b1;
            end
            S_BL: begin
                MA    = MA_PC;
                MD    = MD_OP;
                OP    = OP_PASSB;
                MC    = MC_R14;
                rf_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign abort = r_abort;
    assign state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Directed, table-driven bench for control_sequencer. Each table row gives
// the inputs applied before one rising edge and the state/outputs expected
// just after it. Hand-written sequences cover the memory-timeout corners.
// ---------------------------------------------------------------------------
module tb_control_sequencer;
    import ctrl_pkg::*;

    // Expected control word: strobes are {rf_we, ir_ld, mar_ld, mdr_ld,
    // flags_ld, mfa, rw, abort} from bit 7 down to bit 0.
    typedef struct packed {
        logic [1:0] ma;
        logic [1:0] mb;
        logic [2:0] mc;
        logic       md;
        logic [4:0] op;
        logic       me;
        logic [7:0] stb;
    } ctl_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [31:0] ir_v;
        logic [3:0] flags_v;
        logic       moc_v;
        logic [3:0] exp_state;
        ctl_t       exp_ctl;
    } vec_t;

    localparam ctl_t C_RST  = {2'd0, 2'd0, 3'd0, 1'b0, 5'd0,  1'b0, 8'b0000_0010};
    localparam ctl_t C_F0   = {2'd2, 2'd3, 3'd0, 1'b1, 5'd0,  1'b0, 8'b0010_0010};
    localparam ctl_t C_F0AB = {2'd2, 2'd3, 3'd0, 1'b1, 5'd0,  1'b0, 8'b0010_0011};
    localparam ctl_t C_F1   = {2'd0, 2'd0, 3'd0, 1'b0, 5'd0,  1'b0, 8'b0001_0110};
    localparam ctl_t C_F2   = {2'd2, 2'd0, 3'd3, 1'b1, 5'd20, 1'b0, 8'b1100_0010};
    localparam ctl_t C_DEC  = C_RST;
    localparam ctl_t C_DP   = {2'd0, 2'd1, 3'd0, 1'b0, 5'd0,  1'b0, 8'b1000_0010};
    localparam ctl_t C_DPS  = {2'd0, 2'd1, 3'd0, 1'b0, 5'd0,  1'b0, 8'b1000_1010};
    localparam ctl_t C_LA   = {2'd0, 2'd1, 3'd0, 1'b1, 5'd4,  1'b0, 8'b0010_0010};
    localparam ctl_t C_LW   = C_F1;
    localparam ctl_t C_LB   = {2'd0, 2'd2, 3'd0, 1'b1, 5'd13, 1'b0, 8'b1000_0010};
    localparam ctl_t C_SD   = {2'd1, 2'd0, 3'd0, 1'b1, 5'd13, 1'b1, 8'b0001_0010};
    localparam ctl_t C_SW   = {2'd0, 2'd0, 3'd0, 1'b0, 5'd0,  1'b0, 8'b0000_0100};
    localparam ctl_t C_BR   = {2'd2, 2'd1, 3'd3, 1'b1, 5'd4,  1'b0, 8'b1000_0010};
    localparam ctl_t C_BL   = {2'd2, 2'd0, 3'd2, 1'b1, 5'd13, 1'b0, 8'b1000_0010};

    localparam logic [31:0] I_ADD  = 32'hE082_1003;
    localparam logic [31:0] I_ADDS = 32'hE092_1003;
    localparam logic [31:0] I_BEQ  = 32'h0A00_0004;
    localparam logic [31:0] I_LDR  = 32'hE591_0004;
    localparam logic [31:0] I_STR  = 32'hE581_0004;
    localparam logic [31:0] I_BL   = 32'hEB00_0002;
    localparam logic [31:0] I_NV   = 32'hF082_1003;
    localparam logic [31:0] I_SWI  = 32'hEF00_0000;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        moc;
    logic [1:0]  MA;
    logic [1:0]  MB;
    logic [2:0]  MC;
    logic        MD;
    logic [4:0]  OP;
    logic        ME;
    logic        rf_we;
    logic        ir_ld;
    logic        mar_ld;
    logic        mdr_ld;
    logic        flags_ld;
    logic        mfa;
    logic        rw;
    logic        abort;
    logic [3:0]  state;

    ctl_t act_ctl;
    assign act_ctl = {MA, MB, MC, MD, OP, ME,
                      rf_we, ir_ld, mar_ld, mdr_ld, flags_ld, mfa, rw, abort};

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .ir       (ir),
        .flags    (flags),
        .moc      (moc),
        .MA       (MA),
        .MB       (MB),
        .MC       (MC),
        .MD       (MD),
        .OP       (OP),
        .ME       (ME),
        .rf_we    (rf_we),
        .ir_ld    (ir_ld),
        .mar_ld   (mar_ld),
        .mdr_ld   (mdr_ld),
        .flags_ld (flags_ld),
        .mfa      (mfa),
        .rw       (rw),
        .abort    (abort),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One rising edge, then settle away from the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic rs, input logic [31:0] iv,
                       input logic [3:0] fv, input logic mv,
                       input logic [3:0] es, input ctl_t ec);
        vec_t v;
        v.name      = nm;
        v.rst       = rs;
        v.ir_v      = iv;
        v.flags_v   = fv;
        v.moc_v     = mv;
        v.exp_state = es;
        v.exp_ctl   = ec;
        vecs.push_back(v);
    endtask

    task automatic expect_now(input string nm, input logic [3:0] es, input ctl_t ec);
        check({nm, ".state"}, 32'(state), 32'(es));
        check({nm, ".ctl"}, 32'(act_ctl), 32'(ec));
    endtask

    initial begin
        reset = 1'b1;
        ir    = I_ADD;
        flags = 4'h0;
        moc   = 1'b0;

        // name          rst ir      flags  moc  state  outputs
        add("rst",       1, I_ADD,  4'h0, 0, S_RST, C_RST);
        add("rst_rel",   0, I_ADD,  4'h0, 0, S_F0,  C_F0);
        add("add_f1a",   0, I_ADD,  4'h0, 0, S_F1,  C_F1);
        add("add_f1b",   0, I_ADD,  4'h0, 0, S_F1,  C_F1);
        add("add_f2",    0, I_ADD,  4'h0, 1, S_F2,  C_F2);
        add("add_dec",   0, I_ADD,  4'h0, 0, S_DEC, C_DEC);
        add("add_dp",    0, I_ADD,  4'h0, 0, S_DP,  C_DP);
        add("add_done",  0, I_ADD,  4'h0, 0, S_F0,  C_F0);
        add("beq0_f1",   0, I_BEQ,  4'h0, 1, S_F1,  C_F1);   // moc ignored in F0
        add("beq0_f2",   0, I_BEQ,  4'h0, 1, S_F2,  C_F2);
        add("beq0_dec",  0, I_BEQ,  4'h0, 0, S_DEC, C_DEC);
        add("beq0_skip", 0, I_BEQ,  4'h0, 0, S_F0,  C_F0);
        add("beq1_f1",   0, I_BEQ,  4'h0, 0, S_F1,  C_F1);
        add("beq1_f2",   0, I_BEQ,  4'h0, 1, S_F2,  C_F2);
        add("beq1_dec",  0, I_BEQ,  4'h0, 0, S_DEC, C_DEC);
        add("beq1_br",   0, I_BEQ,  4'h4, 0, S_BR,  C_BR);
        add("beq1_done", 0, I_BEQ,  4'h0, 0, S_F0,  C_F0);
        add("ldr_f1",    0, I_LDR,  4'h0, 0, S_F1,  C_F1);
        add("ldr_f2",    0, I_LDR,  4'h0, 1, S_F2,  C_F2);
        add("ldr_dec",   0, I_LDR,  4'h0, 0, S_DEC, C_DEC);
        add("ldr_la",    0, I_LDR,  4'h0, 0, S_LA,  C_LA);
        add("ldr_lw",    0, I_LDR,  4'h0, 1, S_LW,  C_LW);   // moc ignored in LA
        add("ldr_lb",    0, I_LDR,  4'h0, 1, S_LB,  C_LB);
        add("ldr_done",  0, I_LDR,  4'h0, 0, S_F0,  C_F0);
        add("ldr2_f1",   0, I_LDR,  4'h0, 0, S_F1,  C_F1);
        add("ldr2_f2",   0, I_LDR,  4'h0, 1, S_F2,  C_F2);
        add("ldr2_dec",  0, I_LDR,  4'h0, 0, S_DEC, C_DEC);
        add("ldr2_la",   0, I_LDR,  4'h0, 0, S_LA,  C_LA);
        add("ldr2_lw",   0, I_LDR,  4'h0, 0, S_LW,  C_LW);
        add("ldr2_wait", 0, I_LDR,  4'h0, 0, S_LW,  C_LW);
        add("rst_lw",    1, I_LDR,  4'h0, 1, S_RST, C_RST);  // reset beats moc
        add("rst_hold",  1, I_LDR,  4'h0, 0, S_RST, C_RST);
        add("rst_f0",    0, I_LDR,  4'h0, 0, S_F0,  C_F0);
        add("bl_f1",     0, I_BL,   4'h0, 0, S_F1,  C_F1);
        add("bl_f2",     0, I_BL,   4'h0, 1, S_F2,  C_F2);
        add("bl_dec",    0, I_BL,   4'h0, 0, S_DEC, C_DEC);
        add("bl_link",   0, I_BL,   4'h0, 0, S_BL,  C_BL);
        add("bl_br",     0, I_BL,   4'h0, 0, S_BR,  C_BR);
        add("bl_done",   0, I_BL,   4'h0, 0, S_F0,  C_F0);
        add("nv_f1",     0, I_NV,   4'h0, 0, S_F1,  C_F1);
        add("nv_f2",     0, I_NV,   4'h0, 1, S_F2,  C_F2);
        add("nv_dec",    0, I_NV,   4'h0, 0, S_DEC, C_DEC);
        add("nv_skip",   0, I_NV,   4'hF, 0, S_F0,  C_F0);
        add("swi_f1",    0, I_SWI,  4'h0, 0, S_F1,  C_F1);
        add("swi_f2",    0, I_SWI,  4'h0, 1, S_F2,  C_F2);
        add("swi_dec",   0, I_SWI,  4'h0, 0, S_DEC, C_DEC);
        add("swi_skip",  0, I_SWI,  4'h0, 0, S_F0,  C_F0);
        add("adds_f1",   0, I_ADDS, 4'h0, 0, S_F1,  C_F1);
        add("adds_f2",   0, I_ADDS, 4'h0, 1, S_F2,  C_F2);
        add("adds_dec",  0, I_ADDS, 4'h0, 0, S_DEC, C_DEC);
        add("adds_dp",   0, I_ADDS, 4'h0, 0, S_DP,  C_DPS);
        add("adds_done", 0, I_ADDS, 4'h0, 0, S_F0,  C_F0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            ir    = vecs[i].ir_v;
            flags = vecs[i].flags_v;
            moc   = vecs[i].moc_v;
            step();
            expect_now(vecs[i].name, vecs[i].exp_state, vecs[i].exp_ctl);
        end

        // STR with moc never asserted: 15 cycles in S_SW, then abort pulse.
        reset = 1'b0;
        ir    = I_STR;
        flags = 4'h0;
        moc   = 1'b0;
        step();
        expect_now("str_f1", S_F1, C_F1);
        moc = 1'b1;
        step();
        expect_now("str_f2", S_F2, C_F2);
        moc = 1'b0;
        step();
        expect_now("str_dec", S_DEC, C_DEC);
        step();
        expect_now("str_sa", S_SA, C_LA);
        step();
        expect_now("str_sd", S_SD, C_SD);
        step();
        expect_now("str_sw_0", S_SW, C_SW);
        for (int i = 1; i < 15; i++) begin
            step();
            expect_now($sformatf("str_sw_%0d", i), S_SW, C_SW);
        end
        step();
        expect_now("str_timeout", S_F0, C_F0AB);
        step();
        expect_now("str_abort_end", S_F1, C_F1);

        // moc on the last permitted cycle of an instruction fetch wins.
        for (int i = 1; i < 15; i++) begin
            step();
            check($sformatf("f1_hold_%0d.state", i), 32'(state), 32'(S_F1));
        end
        moc = 1'b1;
        step();
        expect_now("f1_late_moc", S_F2, C_F2);
        moc = 1'b0;
        step();
        expect_now("f1_late_dec", S_DEC, C_DEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
